// File: rtl/picomem_dma_master_if.sv
// PicoMem request/response bundle, used for both the DMA config port and its bus initiator port.
interface picomem_dma_master_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/picomem_dma_master.sv
// Word-copy DMA engine: programmed through s_bus, copies LEN words SRC->DST over m_bus.
// Define DMA_IRQ_EN to add the irq output, CTRL.irq_en and write-1-to-clear of done.
//
// state  | meaning
// IDLE   | no transfer in progress, m_valid low
// RD     | read of cur_src outstanding
// RD_GAP | idle cycle between read and write
// WR     | write of buffered word to cur_dst outstanding
// WR_GAP | idle cycle; finish or issue the next read
module picomem_dma_master #(
    parameter int LEN_BITS = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    picomem_dma_master_if.slave  s_bus,
    picomem_dma_master_if.master m_bus
`ifdef DMA_IRQ_EN
    ,
    output logic                 irq
`endif
);
    typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP} state_t;

    state_t              state_q, state_d;
    logic                s_ready_q, s_ready_d;
    logic [31:0]         s_rdata_q, s_rdata_d;
    logic [31:0]         src_q, src_d, dst_q, dst_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [31:0]         cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
    logic [LEN_BITS-1:0] rem_q, rem_d;
    logic                done_q, done_d;
    logic                m_valid_q, m_valid_d;
    logic [31:0]         m_addr_q, m_addr_d;
    logic [31:0]         m_wdata_q, m_wdata_d;
    logic [3:0]          m_wstrb_q, m_wstrb_d;
    logic                irq_en;
    logic                busy, cfg_acc, cfg_wr, ctrl_wr, start;

`ifdef DMA_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q, irq_d;
    assign irq_en = irq_en_q;
    assign irq    = irq_q;
`else
    assign irq_en = 1'b0;
`endif

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    assign busy    = (state_q != IDLE);
    assign cfg_acc = s_bus.valid && !s_ready_q;
    assign cfg_wr  = cfg_acc && (s_bus.wstrb != 4'b0000);
    assign ctrl_wr = cfg_wr && (s_bus.addr[3:2] == 2'd3) && s_bus.wstrb[0];
    assign start   = ctrl_wr && s_bus.wdata[0] && !busy;

    always_comb begin
        state_d   = state_q;
        s_ready_d = cfg_acc;
        s_rdata_d = '0;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        rem_d     = rem_q;
        done_d    = done_q;
        m_valid_d = m_valid_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
`ifdef DMA_IRQ_EN
        irq_en_d  = irq_en_q;
`endif

        // Read data always reflects the value before any write in the same access.
        if (cfg_acc) begin
            case (s_bus.addr[3:2])
                2'd0:    s_rdata_d = src_q;
                2'd1:    s_rdata_d = dst_q;
                2'd2:    s_rdata_d = 32'(len_q);
                default: s_rdata_d = {29'b0, irq_en, done_q, busy};
            endcase
        end

        if (cfg_wr && !busy) begin
            case (s_bus.addr[3:2])
                2'd0:    src_d = merge_bytes(src_q, s_bus.wdata, s_bus.wstrb);
                2'd1:    dst_d = merge_bytes(dst_q, s_bus.wdata, s_bus.wstrb);
                2'd2:    len_d = LEN_BITS'(merge_bytes(32'(len_q), s_bus.wdata, s_bus.wstrb));
                default: ;
            endcase
        end

`ifdef DMA_IRQ_EN
        if (ctrl_wr) begin
            irq_en_d = s_bus.wdata[2];
            if (s_bus.wdata[1]) done_d = 1'b0;
        end
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_src_d = src_q;
                    cur_dst_d = dst_q;
                    rem_d     = len_q;
                    done_d    = (len_q == '0);
                    if (len_q != '0) begin
                        state_d   = RD;
                        m_valid_d = 1'b1;
                        m_addr_d  = src_q;
                        m_wstrb_d = 4'b0000;
                    end
                end
            end
            RD: begin
                // m_wdata_q doubles as the word buffer between read and write.
                if (m_bus.ready) begin
                    m_wdata_d = m_bus.rdata;
                    m_valid_d = 1'b0;
                    state_d   = RD_GAP;
                end
            end
            RD_GAP: begin
                state_d   = WR;
                m_valid_d = 1'b1;
                m_addr_d  = cur_dst_q;
                m_wstrb_d = 4'b1111;
            end
            WR: begin
                if (m_bus.ready) begin
                    m_valid_d = 1'b0;
                    cur_src_d = cur_src_q + 32'd4;
                    cur_dst_d = cur_dst_q + 32'd4;
                    rem_d     = rem_q - LEN_BITS'(1);
                    state_d   = WR_GAP;
                end
            end
            WR_GAP: begin
                if (rem_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = RD;
                    m_valid_d = 1'b1;
                    m_addr_d  = cur_src_q;
                    m_wstrb_d = 4'b0000;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef DMA_IRQ_EN
        irq_d = done_d && irq_en_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            s_rdata_q <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
`ifdef DMA_IRQ_EN
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            s_rdata_q <= s_rdata_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            m_valid_q <= m_valid_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
`ifdef DMA_IRQ_EN
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
`endif
        end
    end

    assign s_bus.ready = s_ready_q;
    assign s_bus.rdata = s_rdata_q;
    assign m_bus.valid = m_valid_q;
    assign m_bus.addr  = m_addr_q;
    assign m_bus.wdata = m_wdata_q;
    assign m_bus.wstrb = m_wstrb_q;
endmodule
